// File: rtl/mem2nfifo_sched_pkg.sv
// Shared definitions for the memory-to-N-FIFO read scheduler.
//   state_e   : scheduler FSM states (ARB picks a flow, SERVE bursts reads)
//   FLOWS_DEF : default number of flows (power of two, >= 2)
//   BURST_DEF : default maximum reads per grant (>= 1)
package mem2nfifo_sched_pkg;

  localparam int FLOWS_DEF = 8;
  localparam int BURST_DEF = 4;

  typedef enum logic {
    ARB   = 1'b0,
    SERVE = 1'b1
  } state_e;

endpackage

// File: rtl/mem2nfifo_rd_sched_rr_pick.sv
// rr_pick: combinational cyclic priority encoder.
//   req_i   : request vector, one bit per flow
//   start_i : index searched first; search proceeds upward and wraps
//   idx_o   : first requesting index at or after start_i (0 if none)
//   found_o : high when any request bit is set
module rr_pick #(
  parameter int N  = 8,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] start_i,
  output logic [IW-1:0] idx_o,
  output logic          found_o
);

  logic [IW-1:0] cand;

  // N is a power of two, so the IW-bit add wraps N-1 -> 0 for free.
  always_comb begin
    found_o = 1'b0;
    idx_o   = '0;
    cand    = '0;
    for (int i = 0; i < N; i++) begin
      cand = start_i + IW'(i);
      if (!found_o && req_i[cand]) begin
        found_o = 1'b1;
        idx_o   = cand;
      end
    end
  end

endmodule

// File: rtl/mem2nfifo_rd_sched.sv
// mem2nfifo_rd_sched: round-robin burst read scheduler moving words from a
// shared memory (one block per flow) into per-flow output FIFOs.
//   CLK, RESET_N : clock, async active-low reset
//   ENABLE       : scheduler enable
//   FLOW_EMPTY   : per-flow memory block empty
//   FLOW_RDY     : per-flow output FIFO has >= 2 free slots
//   MEM_RD       : memory read strobe (Mealy in SERVE)
//   MEM_FLOW     : flow addressed by MEM_RD (grant in SERVE, else 0)
//   OUT_WR       : one-hot FIFO write, one cycle after MEM_RD
//   BUSY         : FSM in SERVE
module mem2nfifo_rd_sched
  import mem2nfifo_sched_pkg::*;
#(
  parameter int FLOWS = FLOWS_DEF,
  parameter int BURST = BURST_DEF
) (
  input  logic                     CLK,
  input  logic                     RESET_N,
  input  logic                     ENABLE,
  input  logic [FLOWS-1:0]         FLOW_EMPTY,
  input  logic [FLOWS-1:0]         FLOW_RDY,
  output logic                     MEM_RD,
  output logic [$clog2(FLOWS)-1:0] MEM_FLOW,
  output logic [FLOWS-1:0]         OUT_WR,
  output logic                     BUSY
);

  localparam int FW = $clog2(FLOWS);
  localparam int CW = $clog2(BURST) + 1;
  localparam logic [CW-1:0] BURST_C = CW'(BURST);

  state_e         state_q, state_d;
  logic [FW-1:0]  grant_q, grant_d;
  logic [FW-1:0]  last_q, last_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [FLOWS-1:0] out_wr_q, out_wr_d;

  logic [FLOWS-1:0] elig;
  logic [FW-1:0]    pick_idx;
  logic             pick_found;
  logic [CW-1:0]    cnt_inc;

  assign elig = ~FLOW_EMPTY & FLOW_RDY;

  rr_pick #(.N(FLOWS), .IW(FW)) u_pick (
    .req_i   (elig),
    .start_i (last_q + FW'(1)),
    .idx_o   (pick_idx),
    .found_o (pick_found)
  );

  // Read is qualified by live eligibility, so a flow that drops RDY or runs
  // dry mid-burst never sees a read it cannot absorb.
  assign MEM_RD   = (state_q == SERVE) && ENABLE && elig[grant_q];
  assign MEM_FLOW = (state_q == SERVE) ? grant_q : '0;
  assign BUSY     = (state_q == SERVE);
  assign OUT_WR   = out_wr_q;
  assign cnt_inc  = cnt_q + CW'(1);

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    case (state_q)
      ARB: begin
        if (ENABLE && pick_found) begin
          state_d = SERVE;
          grant_d = pick_idx;
          last_d  = pick_idx;
          cnt_d   = '0;
        end
      end
      SERVE: begin
        if (MEM_RD) begin
          cnt_d = cnt_inc;
          // Burst end wins even if eligibility drops in the same cycle.
          if (cnt_inc == BURST_C) state_d = ARB;
        end else if (ENABLE) begin
          state_d = ARB;  // granted flow went ineligible
        end
      end
      default: state_d = ARB;
    endcase
  end

  always_comb begin
    out_wr_d = '0;
    if (MEM_RD) out_wr_d[MEM_FLOW] = 1'b1;
  end

  // Reset parks last_q at FLOWS-1 so the first search starts at flow 0.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q  <= ARB;
      grant_q  <= '0;
      last_q   <= '1;
      cnt_q    <= '0;
      out_wr_q <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      last_q   <= last_d;
      cnt_q    <= cnt_d;
      out_wr_q <= out_wr_d;
    end
  end

endmodule
